// File: rtl/sop_pkg.sv
// Shared definitions for the SOP inverse datapath: FSM encodings, flag bit
// positions and the default sample width.
package sop_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int FLAG_DIV0    = 0;
    localparam int FLAG_NEG     = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_INEXACT = 3;
    localparam int NUM_FLAGS    = 4;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first. The first step runs
// on the start edge; done marks the cycle of the final step, when quotient and
// remainder already show that step's result.
module seq_divider
    import sop_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [2*width:0]   dividend,
    input  logic [width:0]     divisor,
    output logic               busy,
    output logic               done,
    output logic [2*width:0]   quotient,
    output logic [width:0]     remainder
);

    localparam int NW = 2 * width + 1;
    localparam int DW = width + 1;
    localparam int CW = $clog2(NW + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(NW - 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] dvs_q;
    logic [NW-1:0] dvd_q;
    logic [NW-1:0] quo_q;

    logic [DW-1:0] src_rem;
    logic [DW-1:0] src_dvs;
    logic [NW-1:0] src_dvd;
    logic [NW-1:0] src_quo;
    logic [DW:0]   trial;
    logic [DW:0]   diff;
    logic          qbit;
    logic [DW-1:0] rem_d;
    logic [NW-1:0] quo_d;
    logic [NW-1:0] dvd_d;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_dvs = start ? divisor : dvs_q;
        src_dvd = start ? dividend : dvd_q;
        src_quo = start ? '0 : quo_q;
        trial   = {src_rem, src_dvd[NW-1]};
        diff    = trial - {1'b0, src_dvs};
        qbit    = (trial >= {1'b0, src_dvs});
        // A restored remainder is always below the divisor, so its top bit is zero.
        rem_d   = qbit ? diff[DW-1:0] : trial[DW-1:0];
        quo_d   = {src_quo[NW-2:0], qbit};
        dvd_d   = {src_dvd[NW-2:0], 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
        end else begin
            if (start || busy_q) begin
                rem_q <= rem_d;
                dvs_q <= src_dvs;
                dvd_q <= dvd_d;
                quo_q <= quo_d;
            end
            if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(1);
            end else if (busy_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == LAST_STEP);
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/sop_inverse.sv
// Recovers x[n] = (y[n] - c1*x[n-1]) / c0 from a 2-tap sum-of-products stream,
// with valid/ready handshakes and status flags for the degenerate cases.
module sop_inverse
    import sop_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*width:0]   y_in,
    input  logic [width:0]     c0,
    input  logic [width:0]     c1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width-1:0]   x_out,
    output logic               f_div0,
    output logic               f_neg,
    output logic               f_ovf,
    output logic               f_inexact
);

    state_e                 state_q;
    logic [2*width:0]       y_q;
    logic [width:0]         c0_q;
    logic [width:0]         c1_q;
    logic [width-1:0]       xprev_q;
    logic [width-1:0]       x_q;
    logic [NUM_FLAGS-1:0]   flags_q;

    logic [2*width:0]       prod;
    logic [2*width+1:0]     residual;
    logic                   res_neg;
    logic                   div_start;
    logic                   div_busy;
    logic                   div_done;
    logic [2*width:0]       div_quotient;
    logic [width:0]         div_remainder;

    // Product of a (width+1)-bit and a width-bit operand always fits 2*width+1 bits.
    assign prod      = {{width{1'b0}}, c1_q} * {{(width + 1){1'b0}}, xprev_q};
    assign residual  = {1'b0, y_q} - {1'b0, prod};
    assign res_neg   = residual[2*width+1];
    assign div_start = (state_q == ST_SUB) && (c0_q != '0) && !res_neg;

    seq_divider #(
        .width (width)
    ) u_div (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (div_start),
        .dividend  (residual[2*width:0]),
        .divisor   (c0_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            xprev_q <= '0;
            x_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !div_busy) begin
                        y_q     <= y_in;
                        c0_q    <= c0;
                        c1_q    <= c1;
                        flags_q <= '0;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    if (c0_q == '0) begin
                        x_q                <= '0;
                        flags_q[FLAG_DIV0] <= 1'b1;
                        state_q            <= ST_DONE;
                    end else if (res_neg) begin
                        x_q               <= '0;
                        flags_q[FLAG_NEG] <= 1'b1;
                        state_q           <= ST_DONE;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        if (|div_quotient[2*width:width]) begin
                            x_q               <= '1;
                            flags_q[FLAG_OVF] <= 1'b1;
                        end else begin
                            x_q <= div_quotient[width-1:0];
                        end
                        flags_q[FLAG_INEXACT] <= |div_remainder;
                        state_q               <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        xprev_q <= x_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed last so a clear wins over a history update on the same edge.
            if (clr) begin
                xprev_q <= '0;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !div_busy;
    assign out_valid = (state_q == ST_DONE);
    assign x_out     = x_q;
    assign f_div0    = flags_q[FLAG_DIV0];
    assign f_neg     = flags_q[FLAG_NEG];
    assign f_ovf     = flags_q[FLAG_OVF];
    assign f_inexact = flags_q[FLAG_INEXACT];

endmodule
